// File: rtl/lsu_pkg.sv
// Shared op/state encodings and segment defaults for the load/store unit.
package lsu_pkg;

  localparam logic [31:0] DATA_START_DEF = 32'h1000_0000;
  localparam int unsigned DATA_WORDS_DEF = 32'h0004_0000;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LB  = 3'd1,
    OP_LBU = 3'd2,
    OP_SW  = 3'd3,
    OP_SB  = 3'd4,
    OP_LH  = 3'd5,
    OP_LHU = 3'd6,
    OP_SH  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_ACCESS2 = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

  typedef struct packed {
    lsu_op_e     op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic is_store(input lsu_op_e op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_word_we;
  logic        mem_byte_we;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_data_in, mem_word_we, mem_byte_we
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_data_in, mem_word_we, mem_byte_we
  );
endinterface

// File: rtl/load_align.sv
// Load data lane selection and sign/zero extension.
// Halfword ops are handled only when LSU_HALFWORD_EN is defined.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  lsu_op_e     op,
  output logic [31:0] result
);

  logic [7:0] lane_b;

  always_comb begin
    case (addr)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
  end

`ifdef LSU_HALFWORD_EN
  logic [15:0] lane_h;
  assign lane_h = addr[1] ? word[31:16] : word[15:0];
`endif

  always_comb begin
    result = word;
    case (op)
      OP_LB:   result = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  result = {24'd0, lane_b};
`ifdef LSU_HALFWORD_EN
      OP_LH:   result = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  result = {16'd0, lane_h};
`endif
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the pipeline and a data-memory port.
// Define LSU_HALFWORD_EN to build LH/LHU/SH support (SH uses a second byte-write cycle).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] DATA_START = DATA_START_DEF,
  parameter int unsigned DATA_WORDS = DATA_WORDS_DEF
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  localparam logic [33:0] SEG_LO = 34'(DATA_START);
  localparam logic [33:0] SEG_HI = 34'(DATA_START) + (34'(DATA_WORDS) << 2);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d, req_in;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        word_we_q, word_we_d;
  logic        byte_we_q, byte_we_d;
  logic        bad_op_align, in_range, illegal;
  logic [31:0] load_data;

  assign req_in = '{op: lsu_op_e'(bus.req_op), addr: bus.req_addr, wdata: bus.req_wdata};

  // Alignment rules; unbuilt halfword ops are always rejected
  always_comb begin
    bad_op_align = 1'b0;
    case (req_in.op)
      OP_LW, OP_SW:         bad_op_align = (req_in.addr[1:0] != 2'b00);
`ifdef LSU_HALFWORD_EN
      OP_LH, OP_LHU, OP_SH: bad_op_align = req_in.addr[0];
`else
      OP_LH, OP_LHU, OP_SH: bad_op_align = 1'b1;
`endif
      default:              bad_op_align = 1'b0;
    endcase
  end

  assign in_range = (34'(req_in.addr) >= SEG_LO) && (34'(req_in.addr) < SEG_HI);
  assign illegal  = bad_op_align || !in_range;

  load_align u_load_align (
    .word   (bus.mem_data_out),
    .addr   (req_q.addr[1:0]),
    .op     (req_q.op),
    .result (load_data)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    word_we_d   = 1'b0;
    byte_we_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d = req_in;
          if (illegal) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ST_ACCESS;
            mem_addr_d  = req_in.addr;
            mem_wdata_d = req_in.wdata;
            word_we_d   = (req_in.op == OP_SW);
            byte_we_d   = (req_in.op == OP_SB) || (req_in.op == OP_SH);
          end
        end
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = is_store(req_q.op) ? '0 : load_data;
        mem_addr_d  = req_q.addr;
        mem_wdata_d = req_q.wdata;
`ifdef LSU_HALFWORD_EN
        // Upper byte of SH goes out in a second cycle
        if (req_q.op == OP_SH) begin
          state_d     = ST_ACCESS2;
          rsp_valid_d = 1'b0;
          mem_addr_d  = req_q.addr + 32'd1;
          mem_wdata_d = req_q.wdata >> 8;
          byte_we_d   = 1'b1;
        end
`endif
      end
`ifdef LSU_HALFWORD_EN
      ST_ACCESS2: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
`endif
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      word_we_q   <= 1'b0;
      byte_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      word_we_q   <= word_we_d;
      byte_we_q   <= byte_we_d;
    end
  end

  // Ready is gated by reset so nothing is accepted while reset is held
  assign bus.req_ready   = (state_q == ST_IDLE) && reset;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_wdata_q;
  assign bus.mem_word_we = word_we_q;
  assign bus.mem_byte_we = byte_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam logic [31:0] DS  = DATA_START_DEF;
  localparam int unsigned DW  = DATA_WORDS_DEF;
  localparam int          WIN = 64;
`ifdef LSU_HALFWORD_EN
  localparam bit HW = 1'b1;
`else
  localparam bit HW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.DATA_START(DS), .DATA_WORDS(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word index into the small memory window (addresses alias modulo the window)
  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - DS) >> 2;
    return int'(off[5:0]);
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Data memory: combinational read, falling-edge write
  logic [31:0] phys [WIN];
  logic        mem_fill;
  int          wwe_cnt = 0;
  int          bwe_cnt = 0;

  always_comb bus.mem_data_out = phys[widx(bus.mem_addr)];

  always @(negedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < WIN; i++) phys[i] <= init_word(i);
    end else begin
      if (bus.mem_word_we) begin
        phys[widx(bus.mem_addr)] <= bus.mem_data_in;
        wwe_cnt <= wwe_cnt + 1;
      end
      if (bus.mem_byte_we) begin
        phys[widx(bus.mem_addr)][8*bus.mem_addr[1:0] +: 8] <= bus.mem_data_in[7:0];
        bwe_cnt <= bwe_cnt + 1;
      end
    end
  end

  // Reference model: expected outcome of one transaction, updating ref_mem
  logic [31:0] ref_mem [WIN];

  task automatic ref_access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                            output logic err, output logic [31:0] rd, output int lat,
                            output int n_wwe, output int n_bwe);
    longint unsigned la = longint'(a);
    longint unsigned lo = longint'(DS);
    longint unsigned hi = longint'(DS) + 4 * longint'(DW);
    int k = int'(a & 32'd3);
    int i = widx(a);
    logic [31:0] w = ref_mem[i];
    logic [7:0]  b;
    logic [15:0] h;
    err = 1'b0; rd = '0; lat = 2; n_wwe = 0; n_bwe = 0;
    if (la < lo || la >= hi) err = 1'b1;
    case (op)
      3'd0, 3'd3:       if (k != 0) err = 1'b1;
      3'd5, 3'd6, 3'd7: if (!HW || (k % 2) != 0) err = 1'b1;
      default: ;
    endcase
    if (err) begin
      lat = 1;
      return;
    end
    b = 8'(w >> (8 * k));
    h = 16'(w >> (8 * (k & 2)));
    case (op)
      3'd0: rd = w;
      3'd1: rd = {{24{b[7]}}, b};
      3'd2: rd = {24'd0, b};
      3'd3: begin ref_mem[i] = wd; n_wwe = 1; end
      3'd4: begin ref_mem[i][8*k +: 8] = wd[7:0]; n_bwe = 1; end
      3'd5: rd = {{16{h[15]}}, h};
      3'd6: rd = {16'd0, h};
      default: begin
        ref_mem[i][8*k +: 8]     = wd[7:0];
        ref_mem[i][8*k + 8 +: 8] = wd[15:8];
        n_bwe = 2;
        lat   = 3;
      end
    endcase
  endtask

  // Issue one request, hold the response for 'hold' cycles, then consume it
  task automatic do_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat, e_w, e_b, w0, b0, lat;
    string       t;
    t = $sformatf("op%0d@%h", op, a);
    ref_access(op, a, wd, e_err, e_rd, e_lat, e_w, e_b);
    @(negedge clk);
    w0 = wwe_cnt;
    b0 = bwe_cnt;
    check_eq({t, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = wd;
    bus.rsp_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat++;
    end while (!bus.rsp_valid && lat < 8);
    check_eq({t, " latency"}, 32'(lat), 32'(e_lat));
    check_eq({t, " rsp_err"}, 32'(bus.rsp_err), 32'(e_err));
    check_eq({t, " rsp_rdata"}, bus.rsp_rdata, e_rd);
    got = bus.rsp_rdata;
    for (int c = 0; c < hold; c++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 3'($urandom_range(0, 7));
      bus.req_addr  = DS + 32'($urandom_range(0, 255));
      @(negedge clk);
      check_eq({t, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check_eq({t, " hold rdata"}, bus.rsp_rdata, e_rd);
      check_eq({t, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq({t, " idle rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({t, " idle req_ready"}, 32'(bus.req_ready), 32'd1);
    check_eq({t, " word_we cycles"}, 32'(wwe_cnt - w0), 32'(e_w));
    check_eq({t, " byte_we cycles"}, 32'(bwe_cnt - b0), 32'(e_b));
    check_eq({t, " mem word"}, phys[widx(a)], ref_mem[widx(a)]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a, wd;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat, e_w, e_b, r, hold;
    logic [2:0]  op;

    reset = 1'b0; mem_fill = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < WIN; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    check_eq("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    check_eq("rst mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst mem_data_in", bus.mem_data_in, 32'd0);
    check_eq("rst word_we", 32'(bus.mem_word_we), 32'd0);
    check_eq("rst byte_we", 32'(bus.mem_byte_we), 32'd0);
    bus.req_valid = 1'b0;
    #2;
    mem_fill = 1'b0;
    reset = 1'b1;

    // Word load
    do_txn(3'd3, DS + 32'd4, 32'hDEAD_BEEF, 0, got);
    do_txn(3'd0, DS + 32'd4, 32'd0, 0, got);
    check_eq("lw deadbeef", got, 32'hDEAD_BEEF);

    // Byte loads from the top lane
    do_txn(3'd3, DS, 32'h8011_2233, 0, got);
    do_txn(3'd1, DS + 32'd3, 32'd0, 0, got);
    check_eq("lb sign", got, 32'hFFFF_FF80);
    do_txn(3'd2, DS + 32'd3, 32'd0, 0, got);
    check_eq("lbu zero", got, 32'h0000_0080);

    // Halfword store as two byte writes
    do_txn(3'd3, DS, 32'h1122_3344, 0, got);
    do_txn(3'd7, DS + 32'd2, 32'h0000_ABCD, 0, got);
    do_txn(3'd0, DS, 32'd0, 0, got);
    check_eq("lw after sh", got, HW ? 32'hABCD_3344 : 32'h1122_3344);
    do_txn(3'd5, DS + 32'd2, 32'd0, 0, got);

    // Illegal requests
    do_txn(3'd3, DS + 32'd1, 32'hCAFE_F00D, 0, got);
    do_txn(3'd0, 32'h0FFF_FFFC, 32'd0, 0, got);
    do_txn(3'd0, DS + (DW << 2), 32'd0, 0, got);
    do_txn(3'd0, DS + (DW << 2) - 32'd4, 32'd0, 0, got);

    // Response back-pressure
    do_txn(3'd0, DS + 32'd4, 32'd0, 4, got);
    check_eq("lw after hold", got, 32'hDEAD_BEEF);

    // Reset during the ACCESS cycle of a store
    a  = DS + 32'h10;
    wd = 32'h0BAD_F00D;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_addr = a; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("rstmid access we", 32'(bus.mem_word_we), 32'd1);
    reset = 1'b0;
    ref_access(3'd3, a, wd, e_err, e_rd, e_lat, e_w, e_b);
    @(negedge clk);
    check_eq("rstmid req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rstmid rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rstmid word_we", 32'(bus.mem_word_we), 32'd0);
    check_eq("rstmid byte_we", 32'(bus.mem_byte_we), 32'd0);
    check_eq("rstmid mem_addr", bus.mem_addr, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstmid idle req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rstmid no rsp", 32'(bus.rsp_valid), 32'd0);
    do_txn(3'd0, a, 32'd0, 0, got);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 9));
      case (r)
        0:       a = DS - 32'($urandom_range(1, 8));
        1:       a = DS + (DW << 2) + 32'($urandom_range(0, 7));
        2:       a = DS + (DW << 2) - 32'd4 + 32'($urandom_range(0, 3));
        default: a = DS + 32'($urandom_range(0, 4 * WIN - 1));
      endcase
      wd   = $urandom;
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_txn(op, a, wd, hold, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_START, default 32'h10000000, giving the base byte address of the data segment.
REQ-002 SHALL have parameter DATA_WORDS, default 'h40000, giving the data segment size in 32-bit words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset: reset==0 at a rising edge resets the block.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_op in 3, req_addr in 32 and req_wdata in 32, forming the request channel from the pipeline.
REQ-006 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 32 and rsp_err out 1, forming the response channel.
REQ-007 SHALL have ports mem_addr out 32, mem_data_in out 32, mem_data_out in 32, mem_word_we out 1 and mem_byte_we out 1, driving the data-memory port.
- The data memory reads combinationally.
- It writes on the falling clock edge while a write enable is high.
- On a byte write, it merges the low byte of mem_data_in at mem_addr[1:0].

Function
REQ-008 SHALL decode req_op as follows: 0 LW, 1 LB, 2 LBU, 3 SW, 4 SB, 5 LH, 6 LHU, 7 SH.
REQ-009 SHALL implement the states IDLE, ACCESS, ACCESS2 and RESP.
REQ-010 SHALL drive req_ready=1 only in IDLE; a request is accepted at a rising edge where req_valid and req_ready are both 1, and its op, address and data are latched.
REQ-011 SHALL transition on an accepted request from IDLE to ACCESS, or directly to RESP with rsp_err=1 if the request is illegal.
- Illegal requests: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0.
- Also illegal: an address outside [DATA_START, DATA_START+4*DATA_WORDS).
REQ-012 SHALL, in ACCESS, drive mem_addr from the latched address for exactly one cycle.
- SW: mem_word_we=1.
- SB/SH: mem_byte_we=1.
- Loads: both write enables 0.
- mem_data_in = latched wdata.
REQ-013 SHALL, at the end of ACCESS, capture and align mem_data_out for loads and go to RESP, except SH goes to ACCESS2.
REQ-014 SHALL, in ACCESS2 (SH only), drive mem_addr=addr+1, mem_data_in=wdata>>8 and mem_byte_we=1 for one cycle, then go to RESP.
REQ-015 SHALL perform load alignment as follows:
- LB: sign-extend byte addr[1:0].
- LBU: zero-extend byte addr[1:0].
- LH: sign-extend halfword addr[1].
- LHU: zero-extend halfword addr[1].
- LW: pass the word through.
- Byte 0 is bits [7:0].
REQ-016 SHALL hold rsp_valid=1 in RESP with rdata/err stable until rsp_ready=1 at a rising edge, then return to IDLE.
REQ-017 SHALL force rsp_rdata=0 for stores and for errors.
REQ-018 SHALL issue no memory access for an errored request: both write enables stay 0.
REQ-019 SHALL drive both write enables to 0 in every state other than ACCESS/ACCESS2.
REQ-020 SHALL ignore req_valid while not in IDLE; no queuing.
REQ-021 SHALL give a legal non-SH request a latency of 2 cycles from acceptance to rsp_valid, and SH a latency of 3 cycles.

Reset
REQ-022 SHALL, on reset==0 at any rising edge, abort any in-flight request and go to IDLE.
- rsp_valid=0, rsp_err=0, rsp_rdata=0.
- mem_word_we=0, mem_byte_we=0, mem_addr=0, mem_data_in=0.
REQ-023 SHALL hold req_ready=0 during any cycle where reset==0.

Configuration
REQ-024 SHALL compile halfword support (LH, LHU, SH and ACCESS2) only when the macro LSU_HALFWORD_EN is defined.
REQ-025 SHALL, without LSU_HALFWORD_EN, treat ops 5-7 as illegal: immediate RESP with rsp_err=1 and no memory access; ACCESS2 absent.

Structure
REQ-026 SHALL place the op encoding, the state encoding and the DATA_START/DATA_WORDS defaults in shared package lsu_pkg.
REQ-027 SHALL implement load alignment/extension in combinational sub-module load_align (inputs: word, addr[1:0], op; output: 32-bit result).

Verification
REQ-028 SHALL cover LW at 0x10000004 with memory word 0xDEADBEEF -> rsp_valid 2 cycles after accept, rdata=0xDEADBEEF, err=0.
REQ-029 SHALL cover LB/LBU at 0x10000003 with word 0x80112233 -> LB rdata=0xFFFFFF80; LBU rdata=0x00000080.
REQ-030 SHALL cover SH at 0x10000002 with wdata 0x0000ABCD over word 0x11223344 -> two byte-write cycles; a subsequent LW reads 0xABCD3344; the SH response arrives 3 cycles after accept.
REQ-031 SHALL cover SW at 0x10000001, and LW at 0x0FFFFFFC -> rsp_err=1, rdata=0, no write enable ever high, memory unchanged.
REQ-032 SHALL cover rsp_ready held 0 for 4 cycles -> rsp_valid and rdata stable, req_ready=0, a new req_valid ignored; after rsp_ready=1, return to IDLE.
REQ-033 SHALL cover reset==0 asserted during ACCESS of SW -> next cycle IDLE, write enables 0, no response issued; with LSU_HALFWORD_EN undefined, LH -> rsp_err=1.
